// File: rtl/seq_gen_if.sv
// Bundle of request/stream signals between a seq_gen and whoever drives it.
// start/ready: a request is accepted on a rising clk edge where start=1 and ready=1; start while ready=0 is dropped, never queued.
interface seq_gen_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
);
  logic             start;
  logic [WIDTH-1:0] pattern_in;
  logic [REP_W-1:0] repeat_cnt;
  logic             ready;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [1:0]       state_dbg;

  modport master (
    output start, pattern_in, repeat_cnt,
    input  ready, out, out_valid, busy, done, state_dbg
  );

  modport slave (
    input  start, pattern_in, repeat_cnt,
    output ready, out, out_valid, busy, done, state_dbg
  );
endinterface

// File: rtl/seq_gen.sv
// Serial pattern generator: emits a latched WIDTH-bit pattern MSB-first, repeated
// rep times with GAP forced-zero bits between repeats, followed by a one-cycle done.
module seq_gen #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4,
  parameter int GAP   = 0
) (
  input logic     clk,
  input logic     rst,
  seq_gen_if.slave bus
);
  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  BIT_LOAD = CNT_W'(WIDTH - 1);
  localparam logic [2:0]        GAP_LOAD = 3'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPS  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pat_r, pat_nxt;
  logic [WIDTH-1:0] sh_r, sh_nxt;
  logic [REP_W-1:0] rep_r, rep_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_nxt;
  logic [2:0]       gap_cnt, gap_nxt;
  logic             out_r, out_nxt;
  logic             valid_r, valid_nxt;
  logic             busy_r, busy_nxt;
  logic             done_r, done_nxt;

  // out_r always holds the bit currently on the wire; sh_r holds the bits still to come.
  always_comb begin
    state_nxt = state;
    pat_nxt   = pat_r;
    sh_nxt    = sh_r;
    rep_nxt   = rep_r;
    bit_nxt   = bit_cnt;
    gap_nxt   = gap_cnt;
    out_nxt   = 1'b0;
    valid_nxt = 1'b0;
    busy_nxt  = busy_r;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          pat_nxt   = bus.pattern_in;
          sh_nxt    = bus.pattern_in << 1;
          rep_nxt   = (bus.repeat_cnt == '0) ? REP_ONE : bus.repeat_cnt;
          bit_nxt   = BIT_LOAD;
          out_nxt   = bus.pattern_in[WIDTH-1];
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt != '0) begin
          out_nxt   = sh_r[WIDTH-1];
          sh_nxt    = sh_r << 1;
          bit_nxt   = bit_cnt - CNT_W'(1);
          valid_nxt = 1'b1;
        end else if (rep_r > REP_ONE) begin
          rep_nxt   = rep_r - REP_ONE;
          valid_nxt = 1'b1;
          if (GAP > 0) begin
            gap_nxt   = GAP_LOAD;
            state_nxt = GAPS;
          end else begin
            out_nxt = pat_r[WIDTH-1];
            sh_nxt  = pat_r << 1;
            bit_nxt = BIT_LOAD;
          end
        end else begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end
      end
      GAPS: begin
        valid_nxt = 1'b1;
        if (gap_cnt != '0) begin
          gap_nxt = gap_cnt - 3'd1;
        end else begin
          out_nxt   = pat_r[WIDTH-1];
          sh_nxt    = pat_r << 1;
          bit_nxt   = BIT_LOAD;
          state_nxt = SHIFT;
        end
      end
      DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      pat_r   <= '0;
      sh_r    <= '0;
      rep_r   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      out_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      pat_r   <= pat_nxt;
      sh_r    <= sh_nxt;
      rep_r   <= rep_nxt;
      bit_cnt <= bit_nxt;
      gap_cnt <= gap_nxt;
      out_r   <= out_nxt;
      valid_r <= valid_nxt;
      busy_r  <= busy_nxt;
      done_r  <= done_nxt;
    end
  end

  assign bus.ready     = (state == IDLE);
  assign bus.out       = out_r;
  assign bus.out_valid = valid_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.state_dbg = state;
endmodule
